// File: rtl/alu_status_pkg.sv
// Shared flag bit map and status type for the ALU status unit.
// Bit indices are fixed; other blocks decode flags by these names.
package alu_status_pkg;

    localparam int FLAGS_W = 8;

    localparam int FLG_Z  = 0;
    localparam int FLG_C  = 1;
    localparam int FLG_EQ = 2;
    localparam int FLG_LT = 3;
    localparam int FLG_GT = 4;
    localparam int FLG_H  = 5;
    localparam int FLG_V  = 6;
    localparam int FLG_S  = 7;

    typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/alu_status_stack.sv
// LIFO save/restore stack for the status register, with push/pop/swap and misuse detection.
// Latency: top_dat is combinational from stored state; count and err update one cycle after the strobe.
// Backpressure: none; a push when full or a pop when empty is dropped and reported on err.
module alu_status_stack
    import alu_status_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  flags_t           din,
    output flags_t           top_dat,
    output logic             pop_vld,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t           mem_q [DEPTH];
    flags_t           mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             push_vld;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_vld  = pop & ~empty;
    // A push while full is still legal when a valid pop frees the top slot (swap).
    assign push_vld = push & (~full | pop_vld);

    assign top_idx  = AW'(count_q - CNT_W'(1));
    assign wr_idx   = AW'(count_q);
    assign top_dat  = mem_q[top_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push_vld && pop_vld) begin
            mem_d[top_idx] = din;
        end else if (push_vld) begin
            mem_d[wr_idx] = din;
            count_d       = count_q + CNT_W'(1);
        end else if (pop_vld) begin
            count_d = count_q - CNT_W'(1);
        end
        err_d = (push & full & ~pop_vld) | (pop & empty & ~push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign err   = err_q;

endmodule

// File: rtl/alu_status_unit.sv
// Condition-flag generator and 8-bit status register with masked software write and save/restore stack.
// Latency: flags_next is combinational; flags updates one cycle after pop/wr/upd. Optional macro ALU_STATUS_OVERFLOW_EN.
// Backpressure: none; stack misuse is dropped and flagged on err.
module alu_status_unit
    import alu_status_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] f,
    input  logic             a_b,
    input  logic             cn_n,
    input  logic             cnh_n,
    input  logic             cno_n,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             sub,
    input  logic             upd,
    input  logic             wr,
    input  logic [7:0]       wr_mask,
    input  logic [7:0]       wr_data,
    input  logic             push,
    input  logic             pop,
    output logic [7:0]       flags,
    output logic [7:0]       flags_next,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    flags_t status_q, status_d;
    flags_t fn;
    flags_t top_dat;
    logic   pop_vld;

    always_comb begin
        fn         = '0;
        fn[FLG_Z]  = ~|f;
        fn[FLG_C]  = ~cno_n;
        fn[FLG_EQ] = a_b;
        fn[FLG_LT] = ~cn_n & cno_n;
        fn[FLG_GT] = cn_n & ~cno_n;
        fn[FLG_H]  = ~cnh_n;
`ifdef ALU_STATUS_OVERFLOW_EN
        // Operands agree in effective sign but the result sign differs.
        fn[FLG_V]  = (a_msb == (b_msb ^ sub)) & (f[WIDTH-1] != a_msb);
`else
        fn[FLG_V]  = 1'b0;
`endif
        fn[FLG_S]  = f[WIDTH-1];
    end

`ifndef ALU_STATUS_OVERFLOW_EN
    logic unused_ovf;
    assign unused_ovf = a_msb ^ b_msb ^ sub;
`endif

    always_comb begin
        status_d = status_q;
        if (pop_vld) begin
            status_d = top_dat;
        end else if (wr) begin
            status_d = (status_q & ~wr_mask) | (wr_data & wr_mask);
        end else if (upd) begin
            status_d = fn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    alu_status_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (status_q),
        .top_dat (top_dat),
        .pop_vld (pop_vld),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    assign flags      = status_q;
    assign flags_next = fn;

endmodule
